seg_display_arbiter: RTL
========================

# seg_display_arbiter

Time-shares the single 8-bit seven-segment output between three requesters. The requesters are the sequence-detector hit pulse, a digit-display client with a valid/ready handshake, and a lamp-test request. Each grant is held on the display for a fixed minimum window before the display can be re-arbitrated. The block sits between the sequence detector / digit sources and the `uo_out` pad driver, replacing direct writes to the segment register.

## Interface
- `HOLD_CYCLES`, default 16: display window per grant, in clk cycles; legal range ≥ 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  global enable; low freezes all state.
- `det_pulse`  in  1  one-cycle pulse from the sequence detector.
- `dig_valid`  in  1  digit client has a value to show.
- `dig_value`  in  4  BCD digit to show.
- `dig_ready`  out  1  arbiter accepts a digit this cycle (combinational).
- `test_req`  in  1  lamp-test request (level).
- `seg_out`  out  8  registered segment pattern.
- `owner`  out  2  current grant: 0 = idle, 1 = detector, 2 = digit, 3 = test.
- `busy`  out  1  high whenever `owner` ≠ 0.

## Operation
- FSM states:
  - IDLE: `seg_out` = 8'h02 (dash).
  - SHOW_DET: `seg_out` = 8'hFF.
  - SHOW_DIG: `seg_out` = encoded digit.
  - SHOW_TEST: walking-one patterns 8'h80, 8'h40, …, 8'h01.
- Detector latch: `det_pend` is set by `det_pulse` in any state. It is cleared on entry to SHOW_DET. Multiple pulses collapse into one pending request.
- Priority, fixed: detector (`det_pend` or `det_pulse`) > `test_req` > digit.
- Digit handshake:
  - `dig_ready` = IDLE && !`det_pend` && !`det_pulse` && !`test_req` && `ena`.
  - A transfer occurs when `dig_valid` && `dig_ready` at a clock edge; `dig_value` is captured.
- Digit encoding:
  - 0 through 9: FD, C1, 6F, E7, D3, B7, BF, E1, FF, F7 (hex).
  - 10 through 15: 8'h00 (blank).
- Window counter:
  - Loaded with HOLD_CYCLES-1 on every state entry and on every test step.
  - Decrements each enabled cycle.
  - Expiry is when the counter reaches 0.
- Expiry in SHOW_DET or SHOW_DIG: go to SHOW_DET if detector pending; else SHOW_TEST if `test_req`; else IDLE.
- SHOW_TEST:
  - Each expiry advances the walking-one index.
  - Expiry with a detector pending aborts the test and goes to SHOW_DET.
  - After step 7, the exit follows the same rule as the other SHOW states.
  - Because `test_req` is a level, the test restarts while it stays high.
- No mid-window preemption occurs under any condition.
- `ena` low freezes the state, counter, test index, `det_pend` and `seg_out`. `det_pulse` is ignored while `ena` is low.
- Reset values:
  - State IDLE, `seg_out` = 8'h02, `owner` = 0, `busy` = 0.
  - `det_pend` = 0, counter = 0, test index = 0, detection count = 0.
- Reset is applied regardless of `ena`. Reset mid-window aborts the grant; the pending detector request is lost.

## Timing
- A request sampled at edge t in IDLE: the new state and `seg_out` take effect at edge t, so they are visible in cycle t+1.
- Each grant shows for exactly HOLD_CYCLES enabled cycles. A full test sequence lasts 8×HOLD_CYCLES cycles.
- Back-to-back grants on expiry have no IDLE gap. Digit grants are taken only from IDLE, so at least one dash cycle precedes a digit following another grant.
- Simultaneous events in IDLE:
  - `det_pulse` with `dig_valid`: the detector wins and `dig_ready` = 0.
  - `det_pulse` with `test_req`: the detector wins.

## Configuration
- `SEG_ARB_DET_COUNT_EN` defined:
  - A 4-bit detection counter increments on each SHOW_DET entry and saturates at 9. Only `rst_n` clears it.
  - SHOW_DET displays the digit encoding of the count instead of 8'hFF.
- Undefined: no counter exists, and SHOW_DET displays 8'hFF.

## Structure
- Package `seg_arb_pkg` holds:
  - the state enum;
  - the owner codes;
  - the constants SEG_DASH = 8'h02, SEG_ALL = 8'hFF, SEG_BLANK = 8'h00;
  - the 10-entry digit table.
- Sub-module `seg_digit_encoder` is purely combinational: 4-bit in, 8-bit out. It is shared by SHOW_DIG and the count display.

## Test plan
- Reset, then idle 5 cycles → `seg_out` = 8'h02, `owner` = 0, `busy` = 0, `dig_ready` = 1.
- HOLD_CYCLES = 4; in IDLE, `dig_valid` = 1 with `dig_value` = 3 → transfer in 1 cycle, `seg_out` = 8'hE7, `owner` = 2 for 4 cycles, then 8'h02.
- `det_pulse` during a SHOW_DIG window → digit finishes its full window, then `seg_out` = 8'hFF, `owner` = 1 for 4 cycles, then IDLE.
- `test_req` held for 1 cycle in IDLE → sequence 80, 40, … 01 (hex), 4 cycles each, then IDLE. A `det_pulse` at step 2 → SHOW_DET after the step-2 window.
- `det_pulse`, `test_req` and `dig_valid` simultaneous in IDLE → `owner` = 1, `dig_ready` = 0. `dig_value` = 12 later → `seg_out` = 8'h00.
- `ena` low mid-window for 10 cycles → `seg_out` and window frozen, then resume for the remaining cycles. `rst_n` low mid-window → reset values on the next edge. With `SEG_ARB_DET_COUNT_EN`, 11 pulses → count display saturates at 8'hF7.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the state enum, owner codes, segment constants and digit table.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DET,
    S_DIG,
    S_TEST
  } state_e;

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_DET  = 2'd1;
  localparam logic [1:0] OWN_DIG  = 2'd2;
  localparam logic [1:0] OWN_TEST = 2'd3;

  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [7:0] SEG_ALL   = 8'hFF;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Entry 0 sits in the low byte.
  localparam logic [9:0][7:0] DIG_TBL = {
    8'hF7, 8'hFF, 8'hE1, 8'hBF, 8'hB7,
    8'hD3, 8'hE7, 8'h6F, 8'hC1, 8'hFD
  };

  function automatic logic [7:0] seg_enc(
    input logic [3:0] d
  );
    logic [7:0] s;
    s = SEG_BLANK;
    if (d < 4'd10) s = DIG_TBL[d];
    return s;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Digit client valid/ready handshake bundle.
// master: dig_valid, dig_value out, dig_ready in; slave: the reverse.
interface seg_display_arbiter_if;
  logic       dig_valid;
  logic [3:0] dig_value;
  logic       dig_ready;

  modport master (
    output dig_valid,
    output dig_value,
    input  dig_ready
  );

  modport slave (
    input  dig_valid,
    input  dig_value,
    output dig_ready
  );
endinterface

// File: rtl/seg_digit_encoder.sv
// Combinational BCD to segment-pattern encoder, blanks 10..15.
// Ports: i_bcd (4-bit digit), o_seg (8-bit pattern).
module seg_digit_encoder
  import seg_arb_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);
  assign o_seg = seg_enc(i_bcd);
endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares the segment output between detector, digit and lamp test.
// Ports: clk, rst_n (sync, active-low), ena, det_pulse, test_req,
//   dig (slave handshake), seg_out, owner, busy.
// Option: SEG_ARB_DET_COUNT_EN shows a saturating detection count.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 det_pulse,
  input  logic                 test_req,
  seg_display_arbiter_if.slave dig,
  output logic [7:0]           seg_out,
  output logic [1:0]           owner,
  output logic                 busy
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LOAD =
    CW'(HOLD_CYCLES - 1);

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic          r_pend, w_pend_nxt;
  logic [3:0]    r_dig, w_dig_nxt;
  logic [7:0]    r_seg, w_seg_nxt;
  logic          w_enter;
  logic          w_det;
  logic          w_exp;
  logic          w_go_test;
  logic          w_xfer;
  logic [3:0]    w_enc_in;
  logic [7:0]    w_enc;
`ifdef SEG_ARB_DET_COUNT_EN
  logic [3:0]    r_ndet, w_ndet_nxt;
`endif

  assign w_det = r_pend | det_pulse;
  assign w_exp = (r_cnt == '0);

  assign dig.dig_ready = (r_state == S_IDLE)
    && !r_pend && !det_pulse
    && !test_req && ena;

  assign w_go_test = !w_det && test_req;
  assign w_xfer    = dig.dig_valid
    && dig.dig_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_pend_nxt  = r_pend | det_pulse;
    w_dig_nxt   = r_dig;
    w_enter     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_det: begin
            w_state_nxt = S_DET;
            w_enter     = 1'b1;
          end
          w_go_test: begin
            w_state_nxt = S_TEST;
            w_enter     = 1'b1;
          end
          w_xfer: begin
            w_state_nxt = S_DIG;
            w_dig_nxt   = dig.dig_value;
            w_enter     = 1'b1;
          end
          default: ;
        endcase
      end
      S_DET, S_DIG: begin
        if (!w_exp) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_enter = 1'b1;
          if (w_det)
            w_state_nxt = S_DET;
          else if (test_req)
            w_state_nxt = S_TEST;
          else
            w_state_nxt = S_IDLE;
        end
      end
      S_TEST: begin
        if (!w_exp) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_det) begin
          w_state_nxt = S_DET;
          w_enter     = 1'b1;
        end else if (r_idx != 3'd7) begin
          w_idx_nxt = r_idx + 3'd1;
          w_cnt_nxt = LOAD;
        end else begin
          w_enter = 1'b1;
          if (test_req)
            w_state_nxt = S_TEST;
          else
            w_state_nxt = S_IDLE;
        end
      end
    endcase
    if (w_enter) begin
      w_cnt_nxt = LOAD;
      w_idx_nxt = 3'd0;
      if (w_state_nxt == S_DET)
        w_pend_nxt = 1'b0;
    end
  end

`ifdef SEG_ARB_DET_COUNT_EN
  always_comb begin
    w_ndet_nxt = r_ndet;
    if (w_enter && w_state_nxt == S_DET
        && r_ndet != 4'd9)
      w_ndet_nxt = r_ndet + 4'd1;
  end

  assign w_enc_in =
    (w_state_nxt == S_DET) ? w_ndet_nxt
                           : w_dig_nxt;
`else
  assign w_enc_in = w_dig_nxt;
`endif

  seg_digit_encoder u_enc (
    .i_bcd (w_enc_in),
    .o_seg (w_enc)
  );

  always_comb begin
    w_seg_nxt = SEG_DASH;
    unique case (w_state_nxt)
      S_IDLE: w_seg_nxt = SEG_DASH;
`ifdef SEG_ARB_DET_COUNT_EN
      S_DET:  w_seg_nxt = w_enc;
`else
      S_DET:  w_seg_nxt = SEG_ALL;
`endif
      S_DIG:  w_seg_nxt = w_enc;
      S_TEST: w_seg_nxt = 8'h80 >> w_idx_nxt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_pend  <= 1'b0;
      r_dig   <= 4'd0;
      r_seg   <= SEG_DASH;
`ifdef SEG_ARB_DET_COUNT_EN
      r_ndet  <= 4'd0;
`endif
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_pend  <= w_pend_nxt;
      r_dig   <= w_dig_nxt;
      r_seg   <= w_seg_nxt;
`ifdef SEG_ARB_DET_COUNT_EN
      r_ndet  <= w_ndet_nxt;
`endif
    end
  end

  always_comb begin
    owner = OWN_IDLE;
    unique case (r_state)
      S_IDLE: owner = OWN_IDLE;
      S_DET:  owner = OWN_DET;
      S_DIG:  owner = OWN_DIG;
      S_TEST: owner = OWN_TEST;
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign seg_out = r_seg;

endmodule
